// File: rtl/path_output_fifo_pkg.sv
// Shared types and constants for the path-node output FIFO.
// Build option: PATH_FIFO_DROP_CNT_EN adds a saturating dropped-push counter.
package path_output_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    localparam logic [31:0] DEF_DATA_ADR = 32'h0200_0000;
    localparam logic [31:0] DEF_END_ADR  = 32'h0200_0008;
    localparam int          ENTRY_W      = 9;

    typedef struct packed {
        logic       last;
        logic [7:0] node;
    } entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/path_output_fifo_mem.sv
// Purpose: DEPTH x W register array, one write port, combinational head read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the controller decides when to write.
module path_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/path_output_fifo.sv
// Purpose: captures CPU path-node MMIO stores into a FWFT FIFO for a consumer.
// Latency: out_valid one cycle after a push into empty; backpressure via out_ready, drops+overflow when full.
// Option: PATH_FIFO_DROP_CNT_EN adds output drop_cnt.
module path_output_fifo
    import path_output_fifo_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] DATA_ADR = DEF_DATA_ADR,
    parameter logic [31:0] END_ADR  = DEF_END_ADR
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cpu_reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
`ifdef PATH_FIFO_DROP_CNT_EN
    output logic [7:0]               drop_cnt,
`endif
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Async assert, two-flop synchronous release of the internal reset.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_e             r_state;
    logic               r_busy;
    logic               r_overflow;
    logic               r_cpu_reset_q;
    logic               r_end_dropped;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
`ifdef PATH_FIFO_DROP_CNT_EN
    logic [7:0]         r_drop_cnt;
`endif

    logic               w_hit_data;
    logic               w_hit_end;
    logic               w_push_req;
    logic               w_full;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [CNT_W-1:0]   w_count_nxt;
    entry_t             w_wr_entry;
    entry_t             w_head;
    logic [ENTRY_W-1:0] w_head_raw;
    logic               w_unused_wdata;

    assign w_hit_data  = (DataAdr == DATA_ADR);
    assign w_hit_end   = (DataAdr == END_ADR);
    assign w_push_req  = MemWrite && !cpu_reset && (r_state == ST_COLLECT)
                         && (w_hit_data || w_hit_end);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && out_ready;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && w_full && !w_pop;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign w_wr_entry.last = w_hit_end;
    assign w_wr_entry.node = WriteData[7:0];
    assign w_unused_wdata  = ^WriteData[31:8];

    path_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head_raw)
    );

    assign w_head = entry_t'(w_head_raw);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_overflow    <= 1'b0;
            r_cpu_reset_q <= 1'b1;
            r_end_dropped <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
`ifdef PATH_FIFO_DROP_CNT_EN
            r_drop_cnt    <= 8'd0;
`endif
        end else begin
            r_cpu_reset_q <= cpu_reset;
            if (cpu_reset) begin
                r_state       <= ST_IDLE;
                r_busy        <= 1'b0;
                r_end_dropped <= 1'b0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_count       <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= w_count_nxt;
                if (w_drop) begin
                    r_overflow <= 1'b1;
`ifdef PATH_FIFO_DROP_CNT_EN
                    r_drop_cnt <= sat_inc8(r_drop_cnt);
`endif
                end
                case (r_state)
                    ST_IDLE: begin
                        // cpu_reset is low here, so a high last sample is the falling edge.
                        if (r_cpu_reset_q) begin
                            r_state       <= ST_COLLECT;
                            r_busy        <= 1'b1;
                            r_overflow    <= 1'b0;
                            r_end_dropped <= 1'b0;
`ifdef PATH_FIFO_DROP_CNT_EN
                            r_drop_cnt    <= 8'd0;
`endif
                        end
                    end
                    ST_COLLECT: begin
                        if (w_hit_end && (w_push || w_drop)) begin
                            r_state       <= ST_DRAIN;
                            r_end_dropped <= w_drop;
                        end
                    end
                    ST_DRAIN: begin
                        if ((w_pop && w_head.last) ||
                            (r_end_dropped && (w_count_nxt == '0))) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_head.node : 8'd0;
    assign out_last  = w_valid && w_head.last;
    assign count     = r_count;
    assign busy      = r_busy;
    assign overflow  = r_overflow;
`ifdef PATH_FIFO_DROP_CNT_EN
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_path_output_fifo.sv
// Directed bench for path_output_fifo: path capture, overflow, full push+pop, flushes, async reset.
module tb_path_output_fifo;

    localparam logic [31:0] DATA = 32'h0200_0000;
    localparam logic [31:0] ENDA = 32'h0200_0008;
    localparam logic [31:0] OTHR = 32'h0200_0004;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cpu_reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic [3:0]  count;
    logic        busy;
    logic        overflow;
`ifdef PATH_FIFO_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    path_output_fifo #(
        .DEPTH    (8),
        .DATA_ADR (DATA),
        .END_ADR  (ENDA)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_reset (cpu_reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .count     (count),
        .busy      (busy),
`ifdef PATH_FIFO_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [7:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = {24'hABCDEF, d};
        tick();
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1 reset_n = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk("held_busy", busy, 0);

        // Basic path: 0x11, 0x22 then final 0x33, consumer always ready.
        cpu_reset = 1'b0;
        tick();
        chk("collect_busy", busy, 1);
        out_ready = 1'b1;
        store(DATA, 8'h11);
        chk("p1_valid", out_valid, 1);
        chk("p1_data", out_data, 8'h11);
        chk("p1_last", out_last, 0);
        store(DATA, 8'h22);
        chk("p2_data", out_data, 8'h22);
        chk("p2_count", count, 1);
        store(ENDA, 8'h33);
        chk("p3_data", out_data, 8'h33);
        chk("p3_last", out_last, 1);
        chk("p3_busy", busy, 1);
        tick();
        chk("p_done_valid", out_valid, 0);
        chk("p_done_busy", busy, 0);
        chk("p_done_count", count, 0);

        // Overflow: nine stores into eight entries, then a dropped final store.
        cpu_reset = 1'b1;
        tick();
        cpu_reset = 1'b0;
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) store(DATA, 8'(8'h40 + i));
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", out_data, 8'h40);
        chk("ovf_busy", busy, 1);
`ifdef PATH_FIFO_DROP_CNT_EN
        chk("ovf_dropcnt", drop_cnt, 1);
`endif
        store(ENDA, 8'h99);
        chk("enddrop_count", count, 8);
        chk("enddrop_busy", busy, 1);
`ifdef PATH_FIFO_DROP_CNT_EN
        chk("enddrop_dropcnt", drop_cnt, 2);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("drain_count1", count, 1);
        chk("drain_busy1", busy, 1);
        chk("drain_head", out_data, 8'h47);
        tick();
        chk("drain_count0", count, 0);
        chk("drain_busy0", busy, 0);
        chk("drain_ovf_kept", overflow, 1);

        // Fresh collect clears overflow; push and pop together when full.
        cpu_reset = 1'b1;
        tick();
        cpu_reset = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("recollect_ovf", overflow, 0);
        chk("recollect_busy", busy, 1);
`ifdef PATH_FIFO_DROP_CNT_EN
        chk("recollect_dropcnt", drop_cnt, 0);
`endif
        for (int i = 0; i < 8; i++) store(DATA, 8'(8'h60 + i));
        chk("full_count", count, 8);
        chk("full_head", out_data, 8'h60);
        out_ready = 1'b1;
        store(DATA, 8'h68);
        chk("pp_count", count, 8);
        chk("pp_ovf", overflow, 0);
        for (int i = 0; i < 7; i++) begin
            chk("pp_seq", out_data, 32'(8'h61 + i));
            tick();
        end
        chk("pp_tail", out_data, 8'h68);
        chk("pp_tail_count", count, 1);
        tick();
        chk("pp_empty", out_valid, 0);

        // cpu_reset mid-collect flushes.
        out_ready = 1'b0;
        store(DATA, 8'h01);
        store(DATA, 8'h02);
        store(DATA, 8'h03);
        chk("flush_pre", count, 3);
        cpu_reset = 1'b1;
        tick();
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_busy", busy, 0);

        // Ignored stores: while held and to an unmapped address.
        store(DATA, 8'h0A);
        chk("held_store", count, 0);
        cpu_reset = 1'b0;
        tick();
        chk("recollect2_busy", busy, 1);
        store(OTHR, 8'h0B);
        chk("other_adr_count", count, 0);
        chk("other_adr_valid", out_valid, 0);

        // Async reset in the middle of a drain.
        store(DATA, 8'h71);
        store(ENDA, 8'h72);
        chk("drain2_count", count, 2);
        chk("drain2_head", out_data, 8'h71);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_last", out_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ovf", overflow, 0);
`ifdef PATH_FIFO_DROP_CNT_EN
        chk("arst_dropcnt", drop_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
